// File: rtl/rr_trace_packer.sv
// rr_trace_packer: packs variable-width LSB-aligned trace packets densely into OUT_WIDTH-bit words
//   clk, sync_rst             : clock, synchronous active-high reset
//   din/din_width/din_valid   : packet input, din_ready handshake (combinational on dout_ready)
//   finish                    : one-cycle flush request, drains residue as a zero-padded last word
//   dout/dout_valid/dout_last : packed output word, earliest bit at bit 0, dout_ready handshake
//   idle                      : trace complete, held until reset
//   pkt_cnt/word_cnt          : statistics, present only with RR_TRACE_PACKER_STATS_EN defined
module rr_trace_packer #(
    parameter int WIDTH        = 1024,
    parameter int OFFSET_WIDTH = $clog2(WIDTH + 1),
    parameter int OUT_WIDTH    = 512,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    sync_rst,
    input  logic [WIDTH-1:0]        din,
    input  logic [OFFSET_WIDTH-1:0] din_width,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic                    finish,
    output logic [OUT_WIDTH-1:0]    dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    idle,
    output logic [CNT_WIDTH-1:0]    pkt_cnt,
    output logic [CNT_WIDTH-1:0]    word_cnt
);
    localparam int BUF = WIDTH + OUT_WIDTH - 1;
    localparam int FILL_W = $clog2(BUF + 1);
    localparam logic [FILL_W-1:0] OUT_F = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] OUT2_F = FILL_W'(2 * OUT_WIDTH);
    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
    state_t state_q, state_d;
    logic [FILL_W-1:0] fill_q, fill_d, offset;
    logic [BUF-1:0] buf_q, buf_d, base;
    logic [OFFSET_WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] din_m;
    logic in_fire, out_fire;
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= RUN;
            fill_q  <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            buf_q   <= buf_d;
        end
    end
    always_comb begin
        w_sat      = (din_width > OFFSET_WIDTH'(WIDTH)) ? OFFSET_WIDTH'(WIDTH) : din_width;
        // a shift by the full width yields zero, so w_sat == WIDTH keeps every bit
        din_m      = din & ~({WIDTH{1'b1}} << w_sat);
        dout       = buf_q[OUT_WIDTH-1:0];
        idle       = state_q == DONE;
        dout_valid = state_q == FLUSH || (state_q == RUN && fill_q >= OUT_F);
        // in FLUSH the word holding the remaining residue (or nothing at all) is the last one
        dout_last  = state_q == FLUSH && fill_q <= OUT_F;
        din_ready  = state_q == RUN && (fill_q < OUT_F || (fill_q < OUT2_F && dout_ready));
        in_fire    = din_valid && din_ready;
        out_fire   = dout_valid && dout_ready;
        base       = out_fire ? buf_q >> OUT_WIDTH : buf_q;
        // a short final word in FLUSH drops fill to zero rather than underflowing
        offset     = !out_fire ? fill_q : (fill_q > OUT_F ? fill_q - OUT_F : '0);
        fill_d     = in_fire ? offset + FILL_W'(w_sat) : offset;
        buf_d      = in_fire ? base | (BUF'(din_m) << offset) : base;
        state_d    = (state_q == RUN && finish) ? FLUSH :
                     (state_q == FLUSH && out_fire && dout_last) ? DONE : state_q;
    end
`ifdef RR_TRACE_PACKER_STATS_EN
    logic [CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d, word_cnt_q, word_cnt_d;
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + CNT_WIDTH'(in_fire && !(&pkt_cnt_q));
        word_cnt_d = word_cnt_q + CNT_WIDTH'(out_fire && !(&word_cnt_q));
    end
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            pkt_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end
    assign pkt_cnt  = pkt_cnt_q;
    assign word_cnt = word_cnt_q;
`else
    assign pkt_cnt  = '0;
    assign word_cnt = '0;
`endif
endmodule

// File: tb/tb_rr_trace_packer.sv
// tb_rr_trace_packer: bit-stream reference model check of rr_trace_packer
module tb_rr_trace_packer;
    logic clk = 0;
    logic sync_rst = 1;
    logic [1023:0] din = '0;
    logic [10:0] din_width = '0;
    logic din_valid = 0, din_ready, finish = 0;
    logic [511:0] dout;
    logic dout_valid, dout_ready = 1, dout_last, idle;
    logic [31:0] pkt_cnt, word_cnt;
`ifdef RR_TRACE_PACKER_STATS_EN
    localparam bit STATS = 1;
`else
    localparam bit STATS = 0;
`endif
    rr_trace_packer dut (
        .clk(clk), .sync_rst(sync_rst), .din(din), .din_width(din_width),
        .din_valid(din_valid), .din_ready(din_ready), .finish(finish),
        .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .idle(idle), .pkt_cnt(pkt_cnt), .word_cnt(word_cnt)
    );
    always #5 clk = ~clk;
    int n_chk = 0, n_fail = 0;
    bit mq[$];
    bit sref[$];
    logic [511:0] capw[$];
    bit capl[$];
    bit finished, done, rand_ready, last_acc;
    int pm, wm;
    typedef struct {
        logic [1023:0] d;
        logic [10:0] w;
        int n;
        logic [511:0] w0;
    } vec_t;
    vec_t tv[6];
    task automatic chkb(string name, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chkw(string name, logic [511:0] act, logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic chkn(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic clear_model();
        mq.delete(); sref.delete(); capw.delete(); capl.delete();
        finished = 0; done = 0; pm = 0; wm = 0;
    endtask
    // one clock cycle: inputs were set at the preceding negedge
    task automatic step();
        logic [511:0] ew;
        bit ev, er, el;
        int ws;
        if (rand_ready) dout_ready = ($urandom_range(0, 9) < 7);
        #1;
        last_acc = 0;
        if (!sync_rst) begin
            ew = '0;
            for (int i = 0; i < 512 && i < mq.size(); i++) ew[i] = mq[i];
            ev = finished ? !done : mq.size() >= 512;
            er = !finished && (mq.size() < 512 || (mq.size() < 1024 && dout_ready));
            el = finished && !done && mq.size() <= 512;
            chkb("dout_valid", dout_valid, ev);
            chkb("din_ready", din_ready, er);
            if (ev) chkb("dout_last", dout_last, el);
            chkb("idle", idle, done);
            chkw("dout", dout, ew);
            chkn("pkt_cnt", int'(pkt_cnt), STATS ? pm : 0);
            chkn("word_cnt", int'(word_cnt), STATS ? wm : 0);
            if (ev && dout_ready) begin
                capw.push_back(dout);
                capl.push_back(dout_last);
                for (int i = 0; i < 512 && mq.size() > 0; i++) void'(mq.pop_front());
                if (el) done = 1;
                wm++;
            end
            if (din_valid && er) begin
                ws = din_width > 1024 ? 1024 : int'(din_width);
                for (int i = 0; i < ws; i++) begin
                    mq.push_back(din[i]);
                    sref.push_back(din[i]);
                end
                pm++;
                last_acc = 1;
            end
            if (finish && !finished) finished = 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic do_reset(int n);
        sync_rst = 1; din_valid = 0; finish = 0;
        repeat (n) step();
        sync_rst = 0;
        clear_model();
    endtask
    task automatic send(logic [1023:0] d, logic [10:0] w, bit fin);
        din = d; din_width = w; din_valid = 1; finish = fin;
        last_acc = 0;
        for (int i = 0; i < 50 && !last_acc; i++) begin
            step();
            finish = 0;
        end
        din_valid = 0;
        if (!last_acc) begin
            n_chk++; n_fail++;
            $display("FAIL send: packet of width %0d not accepted within 50 cycles", w);
        end
    endtask
    task automatic wait_done();
        for (int i = 0; i < 60 && !done; i++) step();
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL drain: last word not seen within 60 cycles");
        end
    endtask
    task automatic pulse_finish();
        finish = 1;
        step();
        finish = 0;
    endtask
    initial begin
        logic [511:0] e88, aword;
        logic [1023:0] apat, rd;
        int total, errs;
        tv[0] = '{d: {1024{1'b1}}, w: 11'd40, n: 1, w0: 512'hFF_FFFF_FFFF};
        tv[1] = '{d: {1024{1'b1}}, w: 11'd0, n: 1, w0: 512'h0};
        tv[2] = '{d: {512'h1, 512'h3}, w: 11'd2047, n: 2, w0: 512'h3};
        tv[3] = '{d: {1024{1'b1}}, w: 11'd512, n: 1, w0: {512{1'b1}}};
        tv[4] = '{d: {1024{1'b1}}, w: 11'd513, n: 2, w0: {512{1'b1}}};
        tv[5] = '{d: {1024{1'b1}}, w: 11'd1, n: 1, w0: 512'h1};
        rand_ready = 0;
        clear_model();
        @(negedge clk);
        do_reset(5);
        step();
        chkb("rst_din_ready", din_ready, 1'b1);
        // two 300-bit packets, then flush of the 88-bit residue
        send({1024{1'b1}}, 11'd300, 0);
        send({1024{1'b1}}, 11'd300, 0);
        step();
        pulse_finish();
        wait_done();
        step();
        e88 = (512'h1 << 88) - 512'h1;
        chkn("t2_words", capw.size(), 2);
        if (capw.size() == 2) begin
            chkw("t2_w0", capw[0], {512{1'b1}});
            chkb("t2_l0", capl[0], 1'b0);
            chkw("t2_w1", capw[1], e88);
            chkb("t2_l1", capl[1], 1'b1);
        end
        // full-width packet held under backpressure
        do_reset(2);
        apat = {256{4'hA}};
        aword = {128{4'hA}};
        dout_ready = 0;
        send(apat, 11'd1024, 0);
        din = '1; din_width = 11'd8; din_valid = 1;
        repeat (10) step();
        din_valid = 0; dout_ready = 1;
        repeat (4) step();
        chkn("t3_words", capw.size(), 2);
        if (capw.size() == 2) begin
            chkw("t3_w0", capw[0], aword);
            chkw("t3_w1", capw[1], aword);
        end
        // reset while data is buffered discards it
        dout_ready = 0;
        send({1024{1'b1}}, 11'd300, 0);
        send({1024{1'b1}}, 11'd300, 0);
        step();
        do_reset(1);
        dout_ready = 1;
        step();
        step();
        // single packets flushed in the handshake cycle
        for (int k = 0; k < 6; k++) begin
            do_reset(2);
            dout_ready = 1;
            send(tv[k].d, tv[k].w, 1);
            wait_done();
            step();
            chkn($sformatf("tv%0d_words", k), capw.size(), tv[k].n);
            if (capw.size() > 0) begin
                chkw($sformatf("tv%0d_w0", k), capw[0], tv[k].w0);
                chkb($sformatf("tv%0d_last", k), capl[capl.size() - 1], 1'b1);
            end
        end
        // empty flush, then a second finish and input after DONE are ignored
        do_reset(2);
        pulse_finish();
        wait_done();
        finish = 1; din_valid = 1; din = '1; din_width = 11'd64;
        step();
        finish = 0;
        repeat (4) step();
        din_valid = 0;
        chkn("t5_words", capw.size(), 1);
        if (capw.size() == 1) begin
            chkw("t5_w0", capw[0], 512'h0);
            chkb("t5_last", capl[0], 1'b1);
        end
        // random packets with random backpressure
        do_reset(2);
        rand_ready = 1;
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < 32; j++) rd[j*32 +: 32] = $urandom;
            repeat ($urandom_range(0, 2)) step();
            send(rd, 11'($urandom_range(0, 1024)), 0);
        end
        pulse_finish();
        wait_done();
        step();
        rand_ready = 0;
        total = sref.size();
        chkn("rand_words", capw.size(), total == 0 ? 1 : (total + 511) / 512);
        errs = 0;
        for (int i = 0; i < capw.size() * 512; i++)
            if (capw[i / 512][i % 512] !== (i < total ? sref[i] : 1'b0)) errs++;
        chkn("rand_stream_bit_errors", errs, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
